// File: rtl/mc_conunit.sv
// Multi-cycle MIPS-subset control unit: decodes Op/Func, sequences IF/ID/EX/MEM/WB,
// traps illegal instructions and counts retired instructions.
module mc_conunit #(
  parameter int ALUC_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [5:0]        Op,
  input  logic [5:0]        Func,
  input  logic              Z,
  input  logic              Mrdy,
  output logic              Irwrite,
  output logic              Pcwrite,
  output logic [1:0]        Pcsrc,
  output logic              Regrt,
  output logic              Se,
  output logic              Aluqb,
  output logic              Reg2reg,
  output logic              Wreg,
  output logic              Wmem,
  output logic [ALUC_W-1:0] Aluc,
  output logic [2:0]        State,
  output logic              Trap,
  output logic [CNT_W-1:0]  Icount
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_ILL  = 3'd5,
    S_BAD6 = 3'd6,
    S_BAD7 = 3'd7
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;

  logic is_r, r_add, r_sub, r_and, r_or;
  logic is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j;
  logic is_alu, is_legal;
  logic [1:0] alu_op;
  logic retire;
  logic irwrite_c, pcwrite_c, wreg_c, wmem_c;

  always_comb begin
    is_r     = (Op == 6'b000000);
    r_add    = is_r && (Func == 6'b100000);
    r_sub    = is_r && (Func == 6'b100010);
    r_and    = is_r && (Func == 6'b100100);
    r_or     = is_r && (Func == 6'b100101);
    is_addi  = (Op == 6'b001000);
    is_andi  = (Op == 6'b001100);
    is_ori   = (Op == 6'b001101);
    is_lw    = (Op == 6'b100011);
    is_sw    = (Op == 6'b101011);
    is_beq   = (Op == 6'b000100);
    is_bne   = (Op == 6'b000101);
    is_j     = (Op == 6'b000010);
    is_alu   = r_add || r_sub || r_and || r_or || is_addi || is_andi || is_ori;
    is_legal = is_alu || is_lw || is_sw || is_beq || is_bne || is_j;
  end

  // Datapath selects are pure decode; they are only consumed in ID through WB.
  always_comb begin
    Regrt = !is_r;
    Se    = !(is_andi || is_ori);
    Aluqb = is_addi || is_andi || is_ori || is_lw || is_sw;
    if (r_sub || is_beq || is_bne)    alu_op = ALU_SUB;
    else if (r_and || is_andi)        alu_op = ALU_AND;
    else if (r_or || is_ori)          alu_op = ALU_OR;
    else                              alu_op = ALU_ADD;
    Aluc      = '0;
    Aluc[1:0] = alu_op;
  end

  always_comb begin
    state_d   = state_q;
    irwrite_c = 1'b0;
    pcwrite_c = 1'b0;
    wreg_c    = 1'b0;
    wmem_c    = 1'b0;
    Pcsrc     = 2'b00;
    Reg2reg   = 1'b0;
    retire    = 1'b0;
    Trap      = 1'b0;
    unique case (state_q)
      S_IF: begin
        if (Mrdy) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          state_d   = S_ID;
        end
      end
      S_ID: begin
        if (is_j) begin
          pcwrite_c = 1'b1;
          Pcsrc     = 2'b10;
          retire    = 1'b1;
          state_d   = S_IF;
        end else if (!is_legal) begin
          state_d = S_ILL;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_alu) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          Pcsrc     = 2'b01;
          pcwrite_c = (is_beq && Z) || (is_bne && !Z);
          retire    = 1'b1;
          state_d   = S_IF;
        end else begin
          // The instruction register changed under us: treat as illegal.
          state_d = S_ILL;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          wmem_c = 1'b1;
          if (Mrdy) begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else if (is_lw) begin
          if (Mrdy) state_d = S_WB;
        end else begin
          state_d = S_ILL;
        end
      end
      S_WB: begin
        wreg_c  = 1'b1;
        Reg2reg = is_lw;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_ILL: begin
        Trap = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  always_comb begin
    Irwrite = irwrite_c && !Rst;
    Pcwrite = pcwrite_c && !Rst;
    Wreg    = wreg_c && !Rst;
    Wmem    = wmem_c && !Rst;
    State   = state_q;
    Icount  = icount_q;
    icount_d = retire ? (icount_q + CNT_W'(1)) : icount_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IF;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

endmodule

// File: tb/tb_mc_conunit.sv
// Directed, table-driven bench for mc_conunit: a cycle-by-cycle trace table plus
// hand-written sequences for illegal trap, reset mid-instruction and decode selects.
module tb_mc_conunit;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;

  logic        Clk, Rst, Z, Mrdy;
  logic [5:0]  Op, Func;
  logic        Irwrite, Pcwrite, Regrt, Se, Aluqb, Reg2reg, Wreg, Wmem, Trap;
  logic [1:0]  Pcsrc, Aluc;
  logic [2:0]  State;
  logic [15:0] Icount;

  int vectors = 0;
  int miscompares = 0;

  mc_conunit dut (
    .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .Mrdy(Mrdy),
    .Irwrite(Irwrite), .Pcwrite(Pcwrite), .Pcsrc(Pcsrc), .Regrt(Regrt),
    .Se(Se), .Aluqb(Aluqb), .Reg2reg(Reg2reg), .Wreg(Wreg), .Wmem(Wmem),
    .Aluc(Aluc), .State(State), .Trap(Trap), .Icount(Icount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0] op, func;
    logic       z, mrdy;
    logic [2:0] st;
    logic       irw, pcw;
    logic [1:0] pcsrc;
    logic       wreg, wmem, r2r;
    logic [1:0] aluc;
    int         ic;
  } vec_t;

  typedef struct {
    logic [5:0] op, func;
    logic       regrt, se, aluqb;
    logic [1:0] aluc;
  } dec_t;

  vec_t tbl[28];
  dec_t dtbl[11];

  function automatic vec_t mk(logic [5:0] op, logic [5:0] func, logic z, logic mrdy,
                              logic [2:0] st, logic irw, logic pcw, logic [1:0] pcsrc,
                              logic wreg, logic wmem, logic r2r, logic [1:0] aluc, int ic);
    vec_t v;
    v.op = op; v.func = func; v.z = z; v.mrdy = mrdy; v.st = st;
    v.irw = irw; v.pcw = pcw; v.pcsrc = pcsrc; v.wreg = wreg; v.wmem = wmem;
    v.r2r = r2r; v.aluc = aluc; v.ic = ic;
    return v;
  endfunction

  function automatic dec_t md(logic [5:0] op, logic [5:0] func, logic regrt,
                              logic se, logic aluqb, logic [1:0] aluc);
    dec_t d;
    d.op = op; d.func = func; d.regrt = regrt; d.se = se; d.aluqb = aluqb; d.aluc = aluc;
    return d;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] func,
                               input logic z, input logic mrdy);
    Rst = rst; Op = op; Func = func; Z = z; Mrdy = mrdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Cycle-by-cycle trace: add, lw with stalls, beq taken, bne not taken, j, sw.
    tbl[0]  = mk(OP_R,  F_ADD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(OP_R,  F_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(OP_R,  F_ADD, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(OP_R,  F_ADD, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(OP_LW, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(OP_LW, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(OP_LW, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(OP_LW, 0,     0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(OP_LW, 0,     0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(OP_LW, 0,     0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(OP_LW, 0,     0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(OP_LW, 0,     0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(OP_LW, 0,     0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(OP_LW, 0,     0, 1, 4, 0, 0, 0, 1, 0, 1, 0, 1);
    tbl[14] = mk(OP_BEQ, 0,    1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 2);
    tbl[15] = mk(OP_BEQ, 0,    1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2);
    tbl[16] = mk(OP_BEQ, 0,    1, 1, 2, 0, 1, 1, 0, 0, 0, 1, 2);
    tbl[17] = mk(OP_BNE, 0,    1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 3);
    tbl[18] = mk(OP_BNE, 0,    1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3);
    tbl[19] = mk(OP_BNE, 0,    1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 3);
    tbl[20] = mk(OP_J,  0,     0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4);
    tbl[21] = mk(OP_J,  0,     0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 4);
    tbl[22] = mk(OP_SW, 0,     0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 5);
    tbl[23] = mk(OP_SW, 0,     0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5);
    tbl[24] = mk(OP_SW, 0,     0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 5);
    tbl[25] = mk(OP_SW, 0,     0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 5);
    tbl[26] = mk(OP_SW, 0,     0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 5);
    tbl[27] = mk(OP_SW, 0,     0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 6);

    dtbl[0]  = md(OP_R,  6'h20, 0, 1, 0, 2'b00);
    dtbl[1]  = md(OP_R,  6'h22, 0, 1, 0, 2'b01);
    dtbl[2]  = md(OP_R,  6'h24, 0, 1, 0, 2'b10);
    dtbl[3]  = md(OP_R,  6'h25, 0, 1, 0, 2'b11);
    dtbl[4]  = md(6'h08, 0,     1, 1, 1, 2'b00);
    dtbl[5]  = md(6'h0c, 0,     1, 0, 1, 2'b10);
    dtbl[6]  = md(6'h0d, 0,     1, 0, 1, 2'b11);
    dtbl[7]  = md(OP_LW, 0,     1, 1, 1, 2'b00);
    dtbl[8]  = md(OP_SW, 0,     1, 1, 1, 2'b00);
    dtbl[9]  = md(OP_BEQ, 0,    1, 1, 0, 2'b01);
    dtbl[10] = md(OP_BNE, 0,    1, 1, 0, 2'b01);

    // Reset state
    applyStimulus(1, OP_R, F_ADD, 0, 1);
    checkOutput("reset Irwrite forced", int'(Irwrite), 0);
    checkOutput("reset Pcwrite forced", int'(Pcwrite), 0);
    stepClock();
    applyStimulus(0, OP_R, F_ADD, 0, 0);
    checkOutput("reset State", int'(State), 0);
    checkOutput("reset Trap", int'(Trap), 0);
    checkOutput("reset Icount", int'(Icount), 0);
    checkOutput("reset Irwrite stalled", int'(Irwrite), 0);

    for (int i = 0; i < 28; i++) begin
      applyStimulus(0, tbl[i].op, tbl[i].func, tbl[i].z, tbl[i].mrdy);
      checkOutput($sformatf("v%0d State", i), int'(State), int'(tbl[i].st));
      checkOutput($sformatf("v%0d Irwrite", i), int'(Irwrite), int'(tbl[i].irw));
      checkOutput($sformatf("v%0d Pcwrite", i), int'(Pcwrite), int'(tbl[i].pcw));
      if (tbl[i].pcw)
        checkOutput($sformatf("v%0d Pcsrc", i), int'(Pcsrc), int'(tbl[i].pcsrc));
      checkOutput($sformatf("v%0d Wreg", i), int'(Wreg), int'(tbl[i].wreg));
      checkOutput($sformatf("v%0d Wmem", i), int'(Wmem), int'(tbl[i].wmem));
      if (tbl[i].st == 3'd4)
        checkOutput($sformatf("v%0d Reg2reg", i), int'(Reg2reg), int'(tbl[i].r2r));
      if (tbl[i].st >= 3'd1 && tbl[i].st <= 3'd4)
        checkOutput($sformatf("v%0d Aluc", i), int'(Aluc), int'(tbl[i].aluc));
      checkOutput($sformatf("v%0d Trap", i), int'(Trap), 0);
      checkOutput($sformatf("v%0d Icount", i), int'(Icount), tbl[i].ic);
      stepClock();
    end

    // Illegal opcode from ID: trap and hold for 10 cycles
    applyStimulus(0, 6'h3f, 0, 0, 1);
    checkOutput("ill ID State", int'(State), 1);
    stepClock();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 6'h3f, 0, c[0], c[0]);
      checkOutput($sformatf("ill c%0d State", c), int'(State), 5);
      checkOutput($sformatf("ill c%0d Trap", c), int'(Trap), 1);
      checkOutput($sformatf("ill c%0d enables", c),
                  int'({Irwrite, Pcwrite, Wreg, Wmem}), 0);
      checkOutput($sformatf("ill c%0d Icount", c), int'(Icount), 6);
      stepClock();
    end
    applyStimulus(1, 6'h3f, 0, 0, 1);
    checkOutput("ill rst enables", int'({Irwrite, Pcwrite, Wreg, Wmem}), 0);
    stepClock();
    applyStimulus(0, 6'h3f, 0, 0, 0);
    checkOutput("ill after rst State", int'(State), 0);
    checkOutput("ill after rst Trap", int'(Trap), 0);
    checkOutput("ill after rst Icount", int'(Icount), 0);

    // Reset during MEM of sw with memory stalled
    applyStimulus(0, OP_J, 0, 0, 1);
    stepClock();
    stepClock();
    applyStimulus(0, OP_SW, 0, 0, 1);
    stepClock();
    stepClock();
    stepClock();
    applyStimulus(0, OP_SW, 0, 0, 0);
    checkOutput("rstmem State", int'(State), 3);
    checkOutput("rstmem Wmem before", int'(Wmem), 1);
    checkOutput("rstmem Icount before", int'(Icount), 1);
    applyStimulus(1, OP_SW, 0, 0, 0);
    checkOutput("rstmem Wmem in rst", int'(Wmem), 0);
    stepClock();
    applyStimulus(0, OP_SW, 0, 0, 0);
    checkOutput("rstmem State after", int'(State), 0);
    checkOutput("rstmem Icount after", int'(Icount), 0);

    // Decode selects checked in ID, then ID must advance to EX
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1, dtbl[i].op, dtbl[i].func, 0, 1);
      stepClock();
      applyStimulus(0, dtbl[i].op, dtbl[i].func, 0, 1);
      stepClock();
      checkOutput($sformatf("dec%0d State", i), int'(State), 1);
      checkOutput($sformatf("dec%0d Regrt", i), int'(Regrt), int'(dtbl[i].regrt));
      checkOutput($sformatf("dec%0d Se", i), int'(Se), int'(dtbl[i].se));
      checkOutput($sformatf("dec%0d Aluqb", i), int'(Aluqb), int'(dtbl[i].aluqb));
      checkOutput($sformatf("dec%0d Aluc", i), int'(Aluc), int'(dtbl[i].aluc));
      stepClock();
      checkOutput($sformatf("dec%0d next State", i), int'(State), 2);
    end

    // Unknown R-type function is illegal
    applyStimulus(1, OP_R, 6'h21, 0, 1);
    stepClock();
    applyStimulus(0, OP_R, 6'h21, 0, 1);
    stepClock();
    stepClock();
    checkOutput("badfunc State", int'(State), 5);
    checkOutput("badfunc Trap", int'(Trap), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_conunit.md
MC_CONUNIT -- requirements
Module: mc_conunit

Interface
REQ-001 Parameter ALUC_W, default 2, width of the Aluc output (legal >= 2; upper bits beyond 2 are driven 0).
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter Icount.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Op  input  6  opcode field from the instruction register.
REQ-006 Func  input  6  function field from the instruction register.
REQ-007 Z  input  1  ALU zero flag, meaningful in state EX.
REQ-008 Mrdy  input  1  memory ready; completes an instruction fetch or data access in the current cycle.
REQ-009 Irwrite  output  1  load instruction register.
REQ-010 Pcwrite  output  1  load PC from the source selected by Pcsrc.
REQ-011 Pcsrc  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-012 Regrt, Se, Aluqb, Reg2reg  output  1 each  rt-destination, sign-extend, ALU B = immediate, writeback from memory.
REQ-013 Wreg, Wmem  output  1 each  register-file write, data-memory write.
REQ-014 Aluc  output  ALUC_W  00 add, 01 sub, 10 and, 11 or, zero-extended to ALUC_W.
REQ-015 State  output  3  current state code; Trap  output  1  illegal-instruction flag; Icount  output  CNT_W  retired-instruction count.

Function
REQ-016 Decode SHALL recognise: R-type (Op=000000) add 100000, sub 100010, and 100100, or 100101; addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010; all other Op/Func values are illegal.
REQ-017 State codes SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4, ILL=5; codes 6-7 SHALL go to IF on the next edge.
REQ-018 IF: Irwrite=1 and Pcwrite=1 with Pcsrc=00 only while Mrdy=1; transition to ID on Mrdy=1, otherwise hold IF with Irwrite=Pcwrite=0.
REQ-019 ID: j asserts Pcwrite with Pcsrc=10 and returns to IF; an illegal instruction goes to ILL; all others go to EX.
REQ-020 EX: R-type and immediate ALU ops go to WB; lw/sw go to MEM; beq/bne go to IF, with Pcwrite=1 and Pcsrc=01 in EX only when (beq and Z=1) or (bne and Z=0).
REQ-021 MEM: sw drives Wmem=1 for every MEM cycle and goes to IF on Mrdy=1; lw drives Wmem=0 and goes to WB on Mrdy=1; both hold MEM while Mrdy=0.
REQ-022 WB: Wreg=1 for exactly one cycle, Reg2reg=1 for lw and 0 otherwise, then go to IF.
REQ-023 ILL: Trap=1 and every write enable (Irwrite, Pcwrite, Wreg, Wmem) is 0; ILL is held until Rst.
REQ-024 Irwrite, Pcwrite, Wreg and Wmem SHALL be 0 in every state/condition not listed above; no two writes to the same resource occur in one cycle.
REQ-025 Datapath selects SHALL be valid in ID through WB: Regrt=1 for every non-R-type; Se=0 for andi/ori and 1 otherwise; Aluqb=1 for addi/andi/ori/lw/sw; Aluc=sub for sub/beq/bne, and for and/andi, or for or/ori, add otherwise.
REQ-026 Icount SHALL increment by 1, wrapping modulo 2^CNT_W, on each edge where an instruction retires: ID->IF (j), EX->IF (branch taken or not), MEM->IF (sw), WB->IF.
REQ-027 Outputs SHALL be combinational functions of State, Op, Func, Z and Mrdy; the state register and Icount are the only storage.

Reset
REQ-028 With Rst=1 at a rising edge, State SHALL become IF, Icount 0 and Trap 0, overriding every transition, including mid-instruction and ILL.
REQ-029 While Rst=1, Irwrite, Pcwrite, Wreg and Wmem SHALL be forced to 0.

Verification
REQ-030 add with Mrdy=1 throughout -> states IF,ID,EX,WB,IF; Wreg=1 only in WB; Aluc=00; Icount 0->1.
REQ-031 lw with Mrdy=0 for 3 cycles in IF and 2 in MEM -> IF held 4 cycles, MEM held 3; Wmem never 1; Reg2reg=1 and Wreg=1 in WB.
REQ-032 beq with Z=1, then bne with Z=1 -> Pcwrite=1 with Pcsrc=01 in EX for beq only; each returns to IF after EX; Icount +2.
REQ-033 j -> Pcwrite=1 with Pcsrc=10 in ID, next state IF, EX never entered; sw -> Wmem=1 in MEM, WB skipped.
REQ-034 Op=111111 -> State=5, Trap=1, all enables 0 for 10 cycles; Rst pulse -> State=0, Trap=0, Icount=0.
REQ-035 Rst asserted during MEM of sw with Mrdy=0 -> Wmem=0 in the Rst cycle, State=IF after the edge, Icount unchanged except cleared to 0.
